// File: rtl/bp_pkg.sv
// Shared types, default sizes and counter helper for the tagged BTB predictor.
package bp_pkg;

  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_IDX_BITS = 6;
  localparam int unsigned DEF_CTR_W    = 2;
  localparam int unsigned DEF_HIST_W   = 6;

  localparam int unsigned TAG_W   = DEF_PC_W - DEF_IDX_BITS - 2;
  localparam int unsigned ENTRIES = 2 ** DEF_IDX_BITS;
  localparam int unsigned CTR_MAX = (2 ** DEF_CTR_W) - 1;
  localparam int unsigned CTR_WNT = (2 ** (DEF_CTR_W - 1)) - 1;
  localparam int unsigned CTR_WT  = 2 ** (DEF_CTR_W - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [DEF_PC_W-1:0] target;
  } btb_entry_t;

  // Saturating up/down step; never wraps at 0 or ctr_max.
  function automatic int unsigned sat_update(input int unsigned ctr, input logic taken,
                                             input int unsigned ctr_max = CTR_MAX);
    if (taken) begin
      return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Array of saturating direction counters with async reset, flush, one read port
// and one write port (saturating step or set-to-weakly-taken).
module bp_sat_ctr_table #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             upd_en,
  input  logic             set_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             upd_taken
);
  import bp_pkg::*;

  localparam int unsigned N    = 2 ** IDX_W;
  localparam int unsigned MAXV = (2 ** CTR_W) - 1;
  localparam int unsigned WNT  = (2 ** (CTR_W - 1)) - 1;
  localparam int unsigned WT   = 2 ** (CTR_W - 1);

  logic [CTR_W-1:0] ctr_q [N];

  assign rd_ctr = ctr_q[rd_idx];

  // Counter state: reset/flush to weakly-not-taken, then allocate or train.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) ctr_q[i] <= CTR_W'(WNT);
    end else if (flush) begin
      for (int unsigned i = 0; i < N; i++) ctr_q[i] <= CTR_W'(WNT);
    end else if (set_en) begin
      ctr_q[wr_idx] <= CTR_W'(WT);
    end else if (upd_en) begin
      ctr_q[wr_idx] <= CTR_W'(sat_update(32'(ctr_q[wr_idx]), upd_taken, MAXV));
    end
  end

endmodule

// File: rtl/btb_tagged_predictor.sv
// Tagged direct-mapped branch target buffer with saturating direction counters.
// Optional build macro BP_GSHARE_EN moves the counters into a gshare PHT
// indexed by idx ^ global history.
module btb_tagged_predictor #(
  parameter int unsigned PC_W     = bp_pkg::DEF_PC_W,
  parameter int unsigned IDX_BITS = bp_pkg::DEF_IDX_BITS,
  parameter int unsigned CTR_W    = bp_pkg::DEF_CTR_W,
  parameter int unsigned HIST_W   = bp_pkg::DEF_HIST_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  import bp_pkg::*;

  localparam int unsigned TAG_BITS = PC_W - IDX_BITS - 2;
  localparam int unsigned N_ENT    = 2 ** IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_W-1:0]     target;
  } entry_t;

  entry_t ent_q [N_ENT];

  logic [IDX_BITS-1:0] f_idx, u_idx, pht_rd_idx, pht_wr_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  entry_t              f_ent;
  logic                f_hit, upd_fire, ctr_inc, ctr_set;
  logic [CTR_W-1:0]    rd_ctr;
  logic                unused_pc_bits;

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign f_tag = fetch_pc[PC_W-1:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_BITS+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Zero-latency lookup; no bypass from a same-cycle update.
  assign f_ent       = ent_q[f_idx];
  assign f_hit       = f_ent.valid && (f_ent.tag == f_tag);
  assign pred_hit    = f_hit;
  assign pred_taken  = f_hit && rd_ctr[CTR_W-1];
  assign pred_target = f_hit ? f_ent.target : '0;

  assign upd_fire = upd_valid && !stall && !flush;

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;

  assign pht_rd_idx = f_idx ^ IDX_BITS'(ghr_q);
  assign pht_wr_idx = u_idx ^ IDX_BITS'(ghr_q);
  assign ctr_inc    = upd_fire;
  assign ctr_set    = 1'b0;

  // Global history: shift in each accepted outcome, oldest bit drops off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (flush) begin
      ghr_q <= '0;
    end else if (upd_fire) begin
      ghr_q <= HIST_W'({ghr_q, upd_taken});
    end
  end
`else
  entry_t u_ent;
  logic   u_hit;

  assign u_ent      = ent_q[u_idx];
  assign u_hit      = u_ent.valid && (u_ent.tag == u_tag);
  assign pht_rd_idx = f_idx;
  assign pht_wr_idx = u_idx;
  assign ctr_inc    = upd_fire && u_hit;
  assign ctr_set    = upd_fire && !u_hit && upd_taken;
`endif

  // Valid/tag/target array: taken outcomes (re)write the entry, allocating on miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ENT; i++) ent_q[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < N_ENT; i++) ent_q[i] <= '0;
    end else if (upd_fire && upd_taken) begin
      ent_q[u_idx].valid  <= 1'b1;
      ent_q[u_idx].tag    <= u_tag;
      ent_q[u_idx].target <= upd_target;
    end
  end

  bp_sat_ctr_table #(
    .IDX_W (IDX_BITS),
    .CTR_W (CTR_W)
  ) u_ctr_table (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rd_idx    (pht_rd_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (ctr_inc),
    .set_en    (ctr_set),
    .wr_idx    (pht_wr_idx),
    .upd_taken (upd_taken)
  );

endmodule

// File: tb/tb_btb_tagged_predictor.sv
// Scoreboard bench for btb_tagged_predictor (default build, 32-bit PC, 64 entries, 2-bit counters).
module tb_btb_tagged_predictor;

  logic        clk = 1'b0;
  logic        rst, stall, flush, upd_valid, upd_taken;
  logic [31:0] fetch_pc, upd_pc, upd_target;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;

  btb_tagged_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .fetch_pc    (fetch_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 64 direct-mapped slots, counters as plain integers 0..3.
  bit          m_v   [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic model_apply(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    int unsigned i;
    bit hit;
    i   = idx_of(pc);
    hit = m_v[i] && (m_tag[i] == tag_of(pc));
    if (hit && t) begin
      m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      m_tgt[i] = tg;
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (t) begin
      m_v[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tg; m_ctr[i] = 2;
    end
  endtask

  // Effect of the clock edge that just passed, using the inputs held over it.
  task automatic model_edge();
    if (!rst) begin
      if (flush) model_clear();
      else if (upd_valid && !stall) model_apply(upd_pc, upd_taken, upd_target);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input string nm);
    exp_t e;
    int unsigned i;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; stall = s; flush = f; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    if (r) model_clear();
    i     = idx_of(fpc);
    e.hit = m_v[i] && (m_tag[i] == tag_of(fpc));
    e.tk  = e.hit && (m_ctr[i] >= 2);
    e.tgt = e.hit ? m_tgt[i] : 32'h0;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: one lookup result per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (pred_hit !== e.hit || pred_taken !== e.tk || pred_target !== e.tgt) begin
        bad++;
        $display("FAIL %s: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                 e.nm, pred_hit, pred_taken, pred_target, e.hit, e.tk, e.tgt);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; fetch_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    model_clear();
    repeat (2) @(posedge clk);

    step(0, 0, 0, 32'h40,   0, 32'h0,   0, 32'h0,   "reset_lookup");
    step(0, 0, 0, 32'h100,  1, 32'h100, 1, 32'h200, "alloc_same_cycle");
    step(0, 0, 0, 32'h100,  0, 32'h0,   0, 32'h0,   "alloc_hit");
    step(0, 0, 0, 32'h1100, 0, 32'h0,   0, 32'h0,   "alias_miss");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h100, 1, 32'h100, 1, 32'h200, "sat_up");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h100, 1, 32'h100, 0, 32'h0,   "sat_down");
    for (int k = 0; k < 2; k++) step(0, 0, 0, 32'h100, 1, 32'h100, 1, 32'h200, "retrain");
    step(0, 0, 0, 32'h100,  0, 32'h0,   0, 32'h0,   "after_retrain");
    step(0, 0, 0, 32'h2040, 1, 32'h2040, 0, 32'h0,  "nt_no_alloc");
    step(0, 0, 0, 32'h2040, 0, 32'h0,   0, 32'h0,   "nt_no_alloc_chk");
    step(0, 1, 0, 32'h100,  1, 32'h100, 0, 32'h0,   "stall_upd");
    step(0, 0, 0, 32'h100,  0, 32'h0,   0, 32'h0,   "stall_chk");
    step(0, 0, 1, 32'h100,  1, 32'h300, 1, 32'h400, "flush_cycle");
    step(0, 0, 0, 32'h100,  0, 32'h0,   0, 32'h0,   "flush_chk");
    step(0, 0, 0, 32'h300,  0, 32'h0,   0, 32'h0,   "flush_no_alloc");
    step(0, 0, 0, 32'h100,  1, 32'h100, 1, 32'h280, "realloc");
    step(0, 0, 0, 32'h100,  1, 32'h140, 1, 32'h500, "realloc_hit");
    step(1, 0, 0, 32'h40,   1, 32'h40,  1, 32'h600, "reset_mid");
    step(0, 0, 0, 32'h100,  0, 32'h0,   0, 32'h0,   "reset_chk");
    step(0, 0, 0, 32'h40,   0, 32'h0,   0, 32'h0,   "reset_pending_lost");

    for (int k = 0; k < 1500; k++) begin
      logic [31:0] fp, up;
      fp = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      up = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
           fp, ($urandom_range(0, 3) != 0), up, 1'($urandom_range(0, 1)), $urandom, "random");
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
